// File: rtl/cwd_run_ctrl.sv
// Run controller for the LFSR + 12-bit codeword detector pair: seeds the LFSR,
// runs both for a bounded number of cycles, counts hits and reports the outcome.
module cwd_run_ctrl #(
  parameter int LFSR_W = 16,
  parameter int CNT_W  = 24,
  parameter int HIT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic [HIT_W-1:0]  target_hits,
  input  logic              seq_detect,
  output logic              lfsr_load,
  output logic [LFSR_W-1:0] lfsr_seed,
  output logic              lfsr_en,
  output logic              det_rst_n,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              aborted,
  output logic [HIT_W-1:0]  hit_count,
  output logic              first_hit_valid,
  output logic [CNT_W-1:0]  first_hit_cycle
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   seed_q, seed_d;
  logic [CNT_W-1:0]    max_q, max_d;
  logic [HIT_W-1:0]    tgt_q, tgt_d;
  logic [CNT_W-1:0]    cyc_q, cyc_d;
  logic [HIT_W-1:0]    hit_q, hit_d;
  logic                fhv_q, fhv_d;
  logic [CNT_W-1:0]    fhc_q, fhc_d;
  logic                timeout_q, timeout_d;
  logic                aborted_q, aborted_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [HIT_W:0]      hit_sum;

  // Unsaturated sum so the target compare is exact even at the counter ceiling.
  assign hit_sum = {1'b0, hit_q} + {{HIT_W{1'b0}}, seq_detect};

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    max_d     = max_q;
    tgt_d     = tgt_q;
    cyc_d     = cyc_q;
    hit_d     = hit_q;
    fhv_d     = fhv_q;
    fhc_d     = fhc_q;
    timeout_d = timeout_q;
    aborted_d = aborted_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d    = (seed_in == '0) ? LFSR_W'(1) : seed_in;
          max_d     = max_cycles;
          tgt_d     = target_hits;
          hit_d     = '0;
          fhv_d     = 1'b0;
          fhc_d     = '0;
          timeout_d = 1'b0;
          aborted_d = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (max_q == '0) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cyc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (seq_detect) begin
          if (hit_q != '1) hit_d = hit_q + HIT_W'(1);
          if (!fhv_q) begin
            fhv_d = 1'b1;
            fhc_d = cyc_q;
          end
        end
        cyc_d = cyc_q + CNT_W'(1);
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (tgt_q != '0 && hit_sum >= {1'b0, tgt_q}) begin
          state_d = S_DONE;
        end else if (cyc_q == max_q - CNT_W'(1)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      seed_q    <= '0;
      max_q     <= '0;
      tgt_q     <= '0;
      cyc_q     <= '0;
      hit_q     <= '0;
      fhv_q     <= 1'b0;
      fhc_q     <= '0;
      timeout_q <= 1'b0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      max_q     <= max_d;
      tgt_q     <= tgt_d;
      cyc_q     <= cyc_d;
      hit_q     <= hit_d;
      fhv_q     <= fhv_d;
      fhc_q     <= fhc_d;
      timeout_q <= timeout_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign lfsr_load       = (state_q == S_LOAD);
  assign lfsr_en         = (state_q == S_RUN);
  assign det_rst_n       = (state_q == S_RUN);
  assign lfsr_seed       = seed_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign timeout         = timeout_q;
  assign aborted         = aborted_q;
  assign hit_count       = hit_q;
  assign first_hit_valid = fhv_q;
  assign first_hit_cycle = fhc_q;

endmodule

// File: tb/tb_cwd_run_ctrl.sv
// Self-checking bench for cwd_run_ctrl: directed and random runs against a
// per-run outcome model (run length, hit totals, first hit, end reason).
module tb_cwd_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] seed_in = '0;
  logic [23:0] max_cycles = '0;
  logic [7:0]  target_hits = '0;
  logic        seq_detect = 1'b0;
  logic        lfsr_load, lfsr_en, det_rst_n, busy, done, timeout, aborted;
  logic [15:0] lfsr_seed;
  logic [7:0]  hit_count;
  logic        first_hit_valid;
  logic [23:0] first_hit_cycle;

  cwd_run_ctrl #(.LFSR_W(16), .CNT_W(24), .HIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .seed_in(seed_in), .max_cycles(max_cycles), .target_hits(target_hits),
    .seq_detect(seq_detect), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
    .lfsr_en(lfsr_en), .det_rst_n(det_rst_n), .busy(busy), .done(done),
    .timeout(timeout), .aborted(aborted), .hit_count(hit_count),
    .first_hit_valid(first_hit_valid), .first_hit_cycle(first_hit_cycle)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit hits_v [0:2047];
  int pref   [0:2047];
  int m_len, m_hits, m_fhv, m_fhc, m_to, m_ab;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_hits();
    for (int i = 0; i < 2048; i++) hits_v[i] = 1'b0;
  endtask

  // Outcome of one run from the rules: how many RUN cycles, why it ended, hit totals.
  task automatic model(input int maxc, input int tgt, input int abort_at);
    int raw;
    raw = 0; m_fhv = 0; m_fhc = 0; m_to = 0; m_ab = 0; m_len = 0;
    if (abort_at == -2) m_ab = 1;
    else if (maxc == 0) m_to = 1;
    else begin
      for (int r = 0; r < maxc; r++) begin
        pref[r] = raw;
        if (hits_v[r]) begin
          if (m_fhv == 0) begin m_fhv = 1; m_fhc = r; end
          raw++;
        end
        m_len = r + 1;
        if (abort_at == r) begin m_ab = 1; break; end
        if (tgt != 0 && raw >= tgt) break;
        if (r == maxc - 1) m_to = 1;
      end
    end
    m_hits = (raw > 255) ? 255 : raw;
  endtask

  task automatic run_case(input logic [15:0] seed, input int maxc, input int tgt, input int abort_at);
    logic [4:0] ctl_exp;
    int hr;
    seed_in     = seed;
    max_cycles  = 24'(maxc);
    target_hits = 8'(tgt);
    model(maxc, tgt, abort_at);
    @(negedge clk);
    start = 1'b1; abort = 1'b0; seq_detect = 1'($urandom);
    for (int c = 0; c <= m_len + 2; c++) begin
      @(negedge clk);
      ctl_exp = {c == 0, c >= 1 && c <= m_len, c >= 1 && c <= m_len, c <= m_len, c == m_len + 1};
      chk("ctl", 32'({lfsr_load, lfsr_en, det_rst_n, busy, done}), 32'(ctl_exp));
      if (c == 0) chk("seed", 32'(lfsr_seed), (seed == 16'h0) ? 32'd1 : 32'(seed));
      if (c >= 1 && c <= m_len) begin
        hr = (pref[c-1] > 255) ? 255 : pref[c-1];
        chk("hit_run", 32'(hit_count), 32'(hr));
      end
      if (c >= m_len + 1) begin
        chk("hits", 32'(hit_count), 32'(m_hits));
        chk("fhv", 32'(first_hit_valid), 32'(m_fhv));
        chk("fhc", 32'(first_hit_cycle), 32'(m_fhc));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("aborted", 32'(aborted), 32'(m_ab));
      end
      start = (c <= m_len + 1) ? 1'($urandom) : 1'b0;
      if (c == 0) abort = (abort_at == -2);
      else if (c <= m_len) abort = (abort_at == c - 1);
      else abort = 1'($urandom);
      seq_detect = (c >= 1 && c <= m_len) ? hits_v[c-1] : 1'($urandom);
    end
  endtask

  initial begin
    int maxc, tgt, ab, dens, sel;
    logic [15:0] sd;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 32'({lfsr_load, lfsr_en, det_rst_n, busy, done, timeout, aborted, first_hit_valid}), 32'd0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_fhc", 32'(first_hit_cycle), 32'd0);
    chk("rst_seed", 32'(lfsr_seed), 32'd0);
    rst_n = 1'b1;

    clear_hits(); run_case(16'hACE1, 100, 0, -1);
    clear_hits(); hits_v[5] = 1'b1; hits_v[40] = 1'b1; run_case(16'h1234, 1000, 2, -1);
    clear_hits(); hits_v[9] = 1'b1; run_case(16'h0001, 10, 1, -1);
    clear_hits(); run_case(16'h0000, 5, 0, -1);
    clear_hits(); hits_v[3] = 1'b1; run_case(16'h5555, 50, 0, 3);
    clear_hits(); run_case(16'h0007, 0, 3, -1);
    clear_hits(); run_case(16'h0009, 20, 0, -2);
    clear_hits(); for (int i = 0; i < 300; i++) hits_v[i] = 1'b1; run_case(16'hBEEF, 300, 0, -1);
    clear_hits(); for (int i = 0; i < 300; i++) hits_v[i] = 1'b1; run_case(16'hBEEF, 300, 255, -1);

    repeat (40) begin
      clear_hits();
      maxc = $urandom_range(0, 80);
      tgt  = $urandom_range(0, 6);
      dens = $urandom_range(0, 40);
      for (int r = 0; r < maxc; r++) hits_v[r] = ($urandom_range(0, 99) < dens);
      sel = $urandom_range(0, 5);
      ab  = (sel == 0) ? -2 : (sel == 1) ? $urandom_range(0, maxc + 5) : -1;
      sd  = 16'($urandom);
      run_case(sd, maxc, tgt, ab);
    end

    // Reset in the middle of a run must drop it without a done pulse.
    clear_hits();
    seed_in = 16'h4321; max_cycles = 24'd200; target_hits = 8'd0;
    @(negedge clk); start = 1'b1; abort = 1'b0; seq_detect = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (10) begin @(negedge clk); seq_detect = 1'b1; end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_ctl", 32'({lfsr_load, lfsr_en, det_rst_n, busy, done}), 32'd0);
    chk("mid_rst_hits", 32'(hit_count), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_ctl", 32'({lfsr_load, lfsr_en, det_rst_n, busy, done}), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
